// File: rtl/ni_initiator_header_builder.sv
// Initiator-side NI header builder: captures a request, looks up its route in
// the NI routing table, then emits one header flit or a decode-error response.
module ni_initiator_header_builder #(
    parameter int         FLIT_WIDTH = 80,
    parameter logic [3:0] SRC_ID     = 4'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic [3:0]            req_burst,
    output logic [31:0]           lut_address,
    input  logic [6:0]            lut_path,
    input  logic [3:0]            transaction_target,
    input  logic                  failed_decoding,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  err_valid,
    input  logic                  err_ready,
    output logic [7:0]            err_count,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its payload stable until then, ready is ignored
    // while valid is low.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    flit_valid_q;
    logic                    err_valid_q;
    logic [FLIT_WIDTH-1:0]   flit_out_q;
    logic [FLIT_WIDTH-1:0]   header_d;
    logic [31:0]             addr_q;
    logic                    write_q;
    logic [3:0]              burst_q;
    logic [7:0]              err_count_q;

    // Header is assembled from the captured request and the live table answer,
    // and sampled into flit_out_q on the edge that closes LOOKUP.
    always_comb begin
        header_d                 = '0;
        header_d[6:0]            = lut_path;
        header_d[10:7]           = transaction_target;
        header_d[14:11]          = SRC_ID;
        header_d[15]             = write_q;
        header_d[19:16]          = burst_q;
        header_d[51:20]          = addr_q;
        header_d[FLIT_WIDTH-1]   = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            flit_valid_q <= 1'b0;
            err_valid_q  <= 1'b0;
            flit_out_q   <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            burst_q      <= '0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // req_ready stays low during reset and rises one edge later
                    if (!req_ready_q) begin
                        req_ready_q <= 1'b1;
                    end else if (req_valid) begin
                        addr_q      <= req_addr;
                        write_q     <= req_write;
                        burst_q     <= req_burst;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (failed_decoding) begin
                        err_valid_q <= 1'b1;
                        state_q     <= ERROR;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else begin
                        flit_out_q   <= header_d;
                        flit_valid_q <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (flit_ready) begin
                        flit_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                ERROR: begin
                    if (err_ready) begin
                        err_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign flit_valid  = flit_valid_q;
    assign err_valid   = err_valid_q;
    assign flit_out    = flit_out_q;
    assign lut_address = addr_q;
    assign err_count   = err_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ni_initiator_header_builder.sv
// Directed bench for ni_initiator_header_builder with a small address-driven
// routing table model; every expected value is computed here.
module tb_ni_initiator_header_builder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [3:0]  req_burst = '0;
    logic [31:0] lut_address;
    logic [6:0]  lut_path;
    logic [3:0]  transaction_target;
    logic        failed_decoding;
    logic [79:0] flit_out;
    logic        flit_valid;
    logic        flit_ready = 1'b0;
    logic        err_valid;
    logic        err_ready = 1'b0;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [79:0] exp_q[$];
    logic [79:0] exp_flit;
    logic [7:0]  exp_cnt;
    logic [31:0] stream_addr[4];

    always #5 clock = ~clock;

    ni_initiator_header_builder #(.FLIT_WIDTH(80), .SRC_ID(4'h0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_burst(req_burst),
        .lut_address(lut_address), .lut_path(lut_path),
        .transaction_target(transaction_target), .failed_decoding(failed_decoding),
        .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .err_valid(err_valid), .err_ready(err_ready), .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // Routing table: top nibble 0 is unmapped; path/target derived from low bits.
    assign failed_decoding    = (lut_address[31:28] == 4'h0);
    assign lut_path           = {3'b000, lut_address[7:4]} ^ 7'h07;
    assign transaction_target = lut_address[3:0] ^ 4'h5;

    function automatic logic [79:0] hdr(input logic [31:0] a, input logic w, input logic [3:0] b);
        logic [79:0] h;
        h        = '0;
        h[6:0]   = {3'b000, a[7:4]} ^ 7'h07;
        h[10:7]  = a[3:0] ^ 4'h5;
        h[14:11] = 4'h0;
        h[15]    = w;
        h[19:16] = b;
        h[51:20] = a;
        h[79]    = 1'b1;
        return h;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  80'(req_ready),   80'd0);
        check({tag, "_flit_valid"}, 80'(flit_valid),  80'd0);
        check({tag, "_err_valid"},  80'(err_valid),   80'd0);
        check({tag, "_flit_out"},   flit_out,         80'd0);
        check({tag, "_lut_addr"},   80'(lut_address), 80'd0);
        check({tag, "_err_count"},  80'(err_count),   80'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check_reset_outputs("rst");
        step();
        step();
        reset = 1'b0;
        check("rst_release_ready", 80'(req_ready), 80'd0);
        step();
        check("ready_after_reset", 80'(req_ready), 80'd1);
        check("state_idle", 80'(dbg_state), 80'd0);

        // Decoded request: offered in cycle N, flit valid in cycle N+2 for one cycle
        req_valid = 1'b1; req_addr = 32'h10400010; req_write = 1'b1; req_burst = 4'h3;
        flit_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("dec_lookup_ready", 80'(req_ready), 80'd0);
        check("dec_lookup_fv", 80'(flit_valid), 80'd0);
        check("dec_lut_addr", 80'(lut_address), 80'h10400010);
        check("dec_state_lookup", 80'(dbg_state), 80'd1);
        step();
        check("dec_fv", 80'(flit_valid), 80'd1);
        check("dec_ev", 80'(err_valid), 80'd0);
        check("dec_low16", 80'(flit_out[15:0]), 80'h8286);
        check("dec_addr_field", 80'(flit_out[51:20]), 80'h10400010);
        check("dec_marker", 80'(flit_out[79]), 80'd1);
        check("dec_full", flit_out, hdr(32'h10400010, 1'b1, 4'h3));
        step();
        check("dec_fv_drop", 80'(flit_valid), 80'd0);
        check("dec_back_idle", 80'(req_ready), 80'd1);

        // Undecoded address: error response held until err_ready
        req_valid = 1'b1; req_addr = 32'h0; req_write = 1'b0; req_burst = 4'h0;
        err_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("err_lookup_ev", 80'(err_valid), 80'd0);
        step();
        check("err_ev", 80'(err_valid), 80'd1);
        check("err_no_flit", 80'(flit_valid), 80'd0);
        check("err_count_1", 80'(err_count), 80'd1);
        step();
        step();
        check("err_ev_held", 80'(err_valid), 80'd1);
        check("err_ready_low", 80'(req_ready), 80'd0);
        err_ready = 1'b1;
        step();
        err_ready = 1'b0;
        check("err_ev_clear", 80'(err_valid), 80'd0);
        check("err_idle_ready", 80'(req_ready), 80'd1);
        check("err_count_kept", 80'(err_count), 80'd1);

        // Backpressure: flit held 5 cycles, competing request ignored
        flit_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20000020; req_write = 1'b0; req_burst = 4'h7;
        exp_flit = hdr(32'h20000020, 1'b0, 4'h7);
        step();
        req_addr = 32'h30000031; req_write = 1'b1; req_burst = 4'h1;
        step();
        check("bp_fv", 80'(flit_valid), 80'd1);
        check("bp_flit", flit_out, exp_flit);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_flit", flit_out, exp_flit);
            check("bp_hold_fv", 80'(flit_valid), 80'd1);
            check("bp_hold_ready", 80'(req_ready), 80'd0);
        end
        check("bp_lut_not_recaptured", 80'(lut_address), 80'h20000020);
        flit_ready = 1'b1;
        step();
        check("bp_release_idle", 80'(req_ready), 80'd1);
        check("bp_release_fv", 80'(flit_valid), 80'd0);
        step();
        req_valid = 1'b0;
        check("bp_next_accepted", 80'(lut_address), 80'h30000031);
        step();
        check("bp_next_flit", flit_out, hdr(32'h30000031, 1'b1, 4'h1));
        step();

        // Back-to-back stream with req_valid held high
        stream_addr[0] = 32'h50000010;
        stream_addr[1] = 32'h6000002A;
        stream_addr[2] = 32'h70000033;
        stream_addr[3] = 32'h800000F4;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr  = stream_addr[i];
            req_write = i[0];
            req_burst = 4'(i + 2);
            check("bb_ready", 80'(req_ready), 80'd1);
            exp_q.push_back(hdr(stream_addr[i], i[0], 4'(i + 2)));
            step();
            check("bb_lookup_ready", 80'(req_ready), 80'd0);
            step();
            check("bb_fv", 80'(flit_valid), 80'd1);
            check("bb_flit", flit_out, exp_q.pop_front());
            step();
        end
        req_valid = 1'b0;
        check("bb_end_fv", 80'(flit_valid), 80'd0);

        // Error counter saturation
        err_ready = 1'b1;
        req_addr = 32'h00000100;
        exp_cnt = 8'd1;
        for (int i = 0; i < 260; i++) begin
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            step();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("sat_ev", 80'(err_valid & ~flit_valid), 80'd1);
            check("sat_count", 80'(err_count), 80'(exp_cnt));
            step();
        end
        err_ready = 1'b0;
        check("sat_final", 80'(err_count), 80'hFF);

        // Reset while a flit is pending
        flit_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h40000040; req_write = 1'b1; req_burst = 4'hF;
        step();
        req_valid = 1'b0;
        step();
        check("mid_fv", 80'(flit_valid), 80'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        step();
        reset = 1'b0;
        flit_ready = 1'b1;
        step();
        check("mid_ready", 80'(req_ready), 80'd1);
        check("mid_no_stale", 80'(flit_valid), 80'd0);
        step();
        check("mid_no_stale2", 80'(flit_valid), 80'd0);
        check("mid_flit_zero", flit_out, 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
